// File: rtl/sa_feeder.sv
// Systolic-array feeder: buffers one weight tile, shifts it down the array,
// then streams skewed activation vectors into column 0 and drains the pipe.
module sa_feeder #(
    parameter int unsigned N         = 4,
    parameter int unsigned bit_width = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [N*bit_width-1:0]   wt_in,
    input  logic                     wt_valid,
    output logic                     wt_ready,
    input  logic [N*bit_width-1:0]   act_in,
    input  logic                     act_valid,
    output logic                     act_ready,
    input  logic                     act_last,
    output logic                     control,
    output logic [N*bit_width-1:0]   wt_path_out,
    output logic [N*bit_width-1:0]   data_out,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned DW = N * bit_width;
    localparam int unsigned CW = $clog2(2 * N);
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WT,
        SHIFT_WT,
        STREAM,
        DRAIN
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   wt_buf [N];
    logic            wt_fire;
    logic            act_fire;
    logic [DW-1:0]   inj;
    logic [IW-1:0]   rd_idx;

    // Handshake qualification, skew injection value and shift read index
    always_comb begin
        wt_fire  = (state == LOAD_WT) && wt_valid && wt_ready;
        act_fire = (state == STREAM) && act_valid && act_ready;
        inj      = act_fire ? act_in : '0;
        // Shift cycle s (s>=0) registers entry N-2-s for the following cycle
        rd_idx   = IW'(CW'(N - 2) - cnt);
    end

    // Tile sequencing FSM with registered outputs and weight buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wt_ready    <= 1'b0;
            act_ready   <= 1'b0;
            control     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wt_path_out <= '0;
            for (int k = 0; k < int'(N); k++) begin
                wt_buf[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD_WT;
                        wt_ready <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= '0;
                    end
                end
                LOAD_WT: begin
                    if (wt_fire) begin
                        wt_buf[IW'(cnt)] <= wt_in;
                        if (cnt == CW'(N - 1)) begin
                            // Last row goes out first, straight from the input
                            state       <= SHIFT_WT;
                            wt_ready    <= 1'b0;
                            control     <= 1'b1;
                            wt_path_out <= wt_in;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                SHIFT_WT: begin
                    if (cnt == CW'(N - 1)) begin
                        state       <= STREAM;
                        control     <= 1'b0;
                        wt_path_out <= '0;
                        act_ready   <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        wt_path_out <= wt_buf[rd_idx];
                        cnt         <= cnt + CW'(1);
                    end
                end
                STREAM: begin
                    if (act_fire && act_last) begin
                        state     <= DRAIN;
                        act_ready <= 1'b0;
                        cnt       <= '0;
                    end
                end
                DRAIN: begin
                    if (cnt == CW'(2 * N - 2)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-lane skew chains: lane i is delayed by i+1 registers
    for (genvar i = 0; i < int'(N); i++) begin : g_lane
        logic [bit_width-1:0] pipe [i+1];

        // Shift injected lane value down this lane's delay chain
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int d = 0; d <= i; d++) begin
                    pipe[d] <= '0;
                end
            end else begin
                pipe[0] <= inj[i*bit_width +: bit_width];
                for (int d = 1; d <= i; d++) begin
                    pipe[d] <= pipe[d-1];
                end
            end
        end

        assign data_out[i*bit_width +: bit_width] = pipe[i];
    end

endmodule

// File: doc/sa_feeder.md
SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 Parameter: N, default 4, array dimension (rows = columns = lanes); legal range 2..16.
REQ-002 Parameter: bit_width, default 32, width of one weight/activation element.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  synchronous, active-low reset.
REQ-005 Port: start  in  1  begin one tile (weight load, then stream); sampled in IDLE only.
REQ-006 Port: wt_in  in  N*bit_width  one weight row; lane j = bits [j*bit_width +: bit_width].
REQ-007 Port: wt_valid / wt_ready  in / out  1 each  weight-row handshake; transfer when both are high.
REQ-008 Port: act_in  in  N*bit_width  one activation vector; lane i feeds array row i.
REQ-009 Port: act_valid / act_ready  in / out  1 each  activation handshake.
REQ-010 Port: act_last  in  1  marks final activation vector of the tile; qualified by the handshake.
REQ-011 Port: control  out  1  drives MAC control (1 = weight shift, 0 = compute).
REQ-012 Port: wt_path_out  out  N*bit_width  to wt_path_in of the top array row, lane j = column j.
REQ-013 Port: data_out  out  N*bit_width  to data_in of column-0 MACs, lane i = row i, skewed.
REQ-014 Port: busy  out  1  high in every state except IDLE.
REQ-015 Port: done  out  1  single-cycle pulse at tile completion.

Function
REQ-016 States: IDLE, LOAD_WT, SHIFT_WT, STREAM, DRAIN; all outputs registered.
REQ-017 IDLE: wt_ready=0, act_ready=0, control=0, data_out=0, wt_path_out=0; start=1 -> LOAD_WT.
REQ-018 LOAD_WT: wt_ready=1; each transfer writes wt_in to buffer entry k (k = 0..N-1, in arrival order); transfer of entry N-1 -> SHIFT_WT.
REQ-019 SHIFT_WT: exactly N cycles with control=1; on shift cycle s (0..N-1), wt_path_out = buffer[N-1-s], so after N cycles array row r holds buffer[r]; then -> STREAM.
REQ-020 STREAM: control=0, act_ready=1; wt_path_out holds 0.
REQ-021 Skew: an activation accepted at cycle t places lane i on data_out lane i at cycle t+1+i.
REQ-022 Bubble: a STREAM cycle without a transfer injects 0 into every skew lane; data is never duplicated or dropped.
REQ-023 Transfer with act_last=1 -> DRAIN next cycle; act_ready=0 from that cycle on.
REQ-024 DRAIN: inject 0 for exactly 2N-1 cycles (flushes skew registers and array), then pulse done=1 for one cycle and -> IDLE.
REQ-025 The first transfer in STREAM has act_last=1: a one-vector tile is legal and follows REQ-023/024.
REQ-026 start is ignored outside IDLE; wt_valid is ignored outside LOAD_WT; act_valid is ignored outside STREAM.
REQ-027 Counters are wide enough for 2N-1 and must not wrap within a state.
REQ-028 Data is passed bit-exact; no arithmetic, truncation or sign extension.

Reset
REQ-029 rst_n=0 at a clock edge -> next cycle: state IDLE, all outputs 0, buffer, skew registers and counters cleared.
REQ-030 Reset asserted in any state, including mid-SHIFT_WT or mid-STREAM, aborts the tile with no done pulse.
REQ-031 The first start is accepted on the first IDLE cycle after rst_n returns to 1.

Verification
REQ-032 N=4: load rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} -> control=1 for exactly 4 cycles; wt_path_out = row 16.., 12.., 8.., 4.. in that order; a 4x4 MAC array holds the matrix in order.
REQ-033 Stream vectors {1,1,1,1},{2,2,2,2} back-to-back, last on the second -> lane i shows 1 at cycle t+1+i and 2 at t+2+i; done fires 2N-1=7 cycles after DRAIN entry.
REQ-034 Bubble: act_valid low for 2 cycles between vectors -> two all-zero columns appear at the corresponding skewed positions in every lane.
REQ-035 wt_valid toggling 1,0,1,0 in LOAD_WT -> only handshake cycles are captured; SHIFT_WT starts after the 4th transfer.
REQ-036 rst_n=0 during STREAM cycle 3 -> all outputs 0 next cycle, no done pulse; a new tile then completes normally.
REQ-037 start pulsed during STREAM, and wt_valid held high during STREAM -> no state or output effect.
